// File: rtl/dig_evegen_mc.sv
// Multi-channel comparator event generator: per-channel change detection with
// refractory blocking, round-robin arbitration and an output FIFO on a valid/ready bus.
module dig_evegen_mc #(
  parameter int N_CH       = 4,
  parameter int DIST       = 2,
  parameter int REFR_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = $clog2(N_CH)
) (
  input  logic              phi1b_dig,
  input  logic              rstb,
  input  logic [N_CH-1:0]   comp_high,
  input  logic [N_CH-1:0]   en,
  input  logic [REFR_W-1:0] refr_cycles,
  input  logic              ovf_clr,
  output logic [N_CH-1:0]   comp_out,
  output logic [N_CH-1:0]   eve,
  output logic [N_CH-1:0]   polxevent,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [ADDR_W-1:0] ev_addr,
  output logic              ev_pol,
  output logic              ovf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [N_CH-1:0]   chain [DIST+2];
  logic [N_CH-1:0]   eve_d;
  logic [N_CH-1:0]   capture;
  logic [N_CH-1:0]   pend;
  logic [N_CH-1:0]   pol;
  logic [ADDR_W-1:0] rr_ptr;
  logic [ADDR_W-1:0] grant;
  logic              grant_any;
  logic              push;
  logic              pop;
  logic              drop;
  logic [N_CH-1:0]   granted_vec;

  logic [ADDR_W:0]   mem [FIFO_DEPTH];
  logic [ADDR_W:0]   head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  assign comp_out  = chain[0];
  assign eve       = chain[1] ^ chain[DIST+1];
  assign polxevent = eve & chain[1];

  always_ff @(posedge phi1b_dig or negedge rstb) begin
    if (!rstb) begin
      for (int k = 0; k < DIST + 2; k++) chain[k] <= '0;
      eve_d <= '0;
    end else begin
      chain[0] <= comp_high;
      for (int k = 1; k < DIST + 2; k++) chain[k] <= chain[k-1];
      eve_d <= eve;
    end
  end

  // Capture fires on the leading edge of the eve pulse, gated by the refractory counter.
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [REFR_W-1:0] refr_cnt;
      assign capture[gi] = eve[gi] & ~eve_d[gi] & en[gi] & (refr_cnt == '0);
      always_ff @(posedge phi1b_dig or negedge rstb) begin
        if (!rstb)                refr_cnt <= '0;
        else if (capture[gi])     refr_cnt <= refr_cycles;
        else if (refr_cnt != '0)  refr_cnt <= refr_cnt - 1'b1;
      end
    end
  endgenerate

  // Lowest pending channel at or above rr_ptr wins; otherwise lowest below it.
  always_comb begin
    grant_any = 1'b0;
    grant     = '0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (pend[c] && (ADDR_W'(c) < rr_ptr)) begin
        grant_any = 1'b1;
        grant     = ADDR_W'(c);
      end
    end
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (pend[c] && (ADDR_W'(c) >= rr_ptr)) begin
        grant_any = 1'b1;
        grant     = ADDR_W'(c);
      end
    end
  end

  assign pop         = ev_valid & ev_ready;
  assign push        = grant_any & ((count < CNT_W'(FIFO_DEPTH)) | pop);
  assign granted_vec = N_CH'(push) << grant;
  assign drop        = |(capture & pend & ~granted_vec);

  always_ff @(posedge phi1b_dig or negedge rstb) begin
    if (!rstb) begin
      pend   <= '0;
      pol    <= '0;
      rr_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (capture[c]) begin
          if (!pend[c] || granted_vec[c]) begin
            pend[c] <= 1'b1;
            pol[c]  <= chain[1][c];
          end
        end else if (granted_vec[c]) begin
          pend[c] <= 1'b0;
        end
      end
      if (push) rr_ptr <= (grant == ADDR_W'(N_CH - 1)) ? '0 : grant + 1'b1;
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge phi1b_dig) begin
    if (push) mem[wr_ptr] <= {grant, pol[grant]};
  end

  always_ff @(posedge phi1b_dig or negedge rstb) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head     = mem[rd_ptr];
  assign ev_valid = (count != '0);
  assign ev_addr  = ev_valid ? head[ADDR_W:1] : '0;
  assign ev_pol   = ev_valid & head[0];

endmodule

// File: tb/tb_dig_evegen_mc.sv
// Bench for dig_evegen_mc: directed scenarios plus random traffic, compared every
// cycle against a sample-history / event-queue reference model.
module tb_dig_evegen_mc;
  localparam int N = 4;
  localparam int D = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rstb;
  logic [3:0] comp_high, en, refr_cycles;
  logic       ovf_clr, ev_ready;
  logic [3:0] comp_out, eve, polxevent;
  logic       ev_valid, ev_pol, ovf;
  logic [1:0] ev_addr;

  int tests = 0;
  int fails = 0;
  bit en_phase = 0;

  dig_evegen_mc dut (
    .phi1b_dig(clk), .rstb(rstb), .comp_high(comp_high), .en(en),
    .refr_cycles(refr_cycles), .ovf_clr(ovf_clr), .comp_out(comp_out),
    .eve(eve), .polxevent(polxevent), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_addr(ev_addr), .ev_pol(ev_pol), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // hist[k] holds the comparator word sampled k edges ago.
  bit [3:0] hist [0:D+1];
  bit [3:0] m_eve_d, m_pend, m_pol;
  int       m_refr [N];
  int       m_rr;
  bit       m_ovf;
  int       evq [$];   // entries: addr*2 + pol

  task automatic model_reset();
    for (int k = 0; k <= D + 1; k++) hist[k] = '0;
    m_eve_d = '0; m_pend = '0; m_pol = '0; m_rr = 0; m_ovf = 0;
    for (int c = 0; c < N; c++) m_refr[c] = 0;
    evq.delete();
  endtask

  task automatic model_edge();
    bit [3:0] eve_c, cap;
    bit pop, push, drop;
    int g;
    eve_c = hist[1] ^ hist[D+1];
    cap = '0;
    for (int c = 0; c < N; c++)
      cap[c] = eve_c[c] & ~m_eve_d[c] & en[c] & (m_refr[c] == 0);
    pop = (evq.size() > 0) && ev_ready;
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
    push = (g >= 0) && (evq.size() < DEPTH || pop);
    if (pop) void'(evq.pop_front());
    if (push) evq.push_back(g * 2 + int'(m_pol[g]));
    drop = 0;
    for (int c = 0; c < N; c++) begin
      if (cap[c]) begin
        if (m_pend[c] && !(push && g == c)) drop = 1;
        else begin m_pend[c] = 1; m_pol[c] = hist[1][c]; end
        m_refr[c] = int'(refr_cycles);
      end else begin
        if (push && g == c) m_pend[c] = 0;
        if (m_refr[c] > 0) m_refr[c]--;
      end
    end
    if (push) m_rr = (g + 1) % N;
    if (drop) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    m_eve_d = eve_c;
    for (int k = D + 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = comp_high;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    bit [3:0] e;
    e = hist[1] ^ hist[D+1];
    chk("comp_out", comp_out, hist[0]);
    chk("eve", eve, e);
    chk("polxevent", polxevent, e & hist[1]);
    chk("ev_valid", ev_valid, evq.size() > 0);
    chk("ev_addr", ev_addr, evq.size() > 0 ? evq[0] / 2 : 0);
    chk("ev_pol", ev_pol, evq.size() > 0 ? evq[0] % 2 : 0);
    chk("ovf", ovf, m_ovf);
    if (en_phase) chk("en_block_addr2", ev_valid && ev_addr == 2'd2, 0);
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (rstb) model_edge(); else model_reset();
      #1;
      check_all();
      $display("[TB] t=%0t comp=%h eve=%h valid=%0b addr=%0d pol=%0b ovf=%0b",
               $time, comp_high, eve, ev_valid, ev_addr, ev_pol, ovf);
    end
  endtask

  initial begin
    rstb = 0; comp_high = 4'hF; en = 4'hF; refr_cycles = 0; ovf_clr = 0; ev_ready = 1;
    model_reset();
    // Reset held while inputs toggle: everything stays 0.
    for (int i = 0; i < 4; i++) begin
      cyc();
      comp_high = ~comp_high;
    end
    comp_high = 4'h0;
    cyc();
    rstb = 1;
    cyc(3);
    comp_high = 4'hA;
    cyc();
    chk("release_follow", comp_out, 4'hA);
    comp_high = 4'h0;
    cyc(8);

    // Single event on ch2, rising then falling.
    comp_high = 4'h4;
    cyc(2);
    chk("single_eve2", eve[2], 1'b1);
    chk("single_polx2", polxevent[2], 1'b1);
    cyc();
    chk("single_eve2_2nd", eve[2], 1'b1);
    cyc();
    chk("single_valid", ev_valid, 1'b1);
    chk("single_addr", ev_addr, 2'd2);
    chk("single_pol", ev_pol, 1'b1);
    cyc();
    chk("single_drained", ev_valid, 1'b0);
    cyc(4);
    comp_high = 4'h0;
    cyc(2);
    chk("fall_eve2", eve[2], 1'b1);
    chk("fall_polx2", polxevent[2], 1'b0);
    cyc(2);
    chk("fall_pol", ev_pol, 1'b0);
    cyc(4);

    // Ch3 event moves rr_ptr back to 0, then two round-robin bursts.
    comp_high = 4'h8; cyc(6);
    comp_high = 4'h0; cyc(6);
    comp_high = 4'hF; cyc(10);
    comp_high = 4'h0; cyc(10);

    // Refractory window on ch1.
    refr_cycles = 5;
    for (int i = 0; i < 10; i++) begin
      comp_high[1] = ~comp_high[1];
      cyc(4);
    end
    chk("refr_no_ovf", ovf, 1'b0);
    comp_high = 4'h0; refr_cycles = 0;
    cyc(10);

    // Backpressure: 4 events fill the FIFO, 4 more wait pending, a 9th drops.
    ev_ready = 0;
    comp_high = 4'hF; cyc(8);
    comp_high = 4'h0; cyc(8);
    chk("bp_ovf_clear", ovf, 1'b0);
    chk("bp_valid", ev_valid, 1'b1);
    comp_high = 4'h1; cyc(8);
    chk("bp_ovf_set", ovf, 1'b1);
    ev_ready = 1;
    cyc(12);
    chk("bp_drained", ev_valid, 1'b0);
    chk("bp_ovf_sticky", ovf, 1'b1);
    ovf_clr = 1; cyc(); ovf_clr = 0;
    chk("ovf_cleared", ovf, 1'b0);
    comp_high = 4'h0; cyc(8);

    // Enable mask blocks ch2 while its eve still pulses.
    en = 4'b1011;
    cyc(10);
    en_phase = 1;
    for (int i = 0; i < 80; i++) begin
      comp_high = 4'($urandom);
      cyc();
    end
    en_phase = 0;
    en = 4'hF;

    // Random traffic with backpressure, refractory and clears.
    for (int i = 0; i < 400; i++) begin
      comp_high   = 4'($urandom);
      en          = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      ev_ready    = ($urandom_range(0, 2) != 0);
      refr_cycles = 4'($urandom_range(0, 3));
      ovf_clr     = ($urandom_range(0, 15) == 0);
      cyc();
    end

    // Asynchronous reset mid-operation discards all queued work.
    ev_ready = 0; comp_high = 4'h5; cyc(3); comp_high = 4'hA; cyc(3);
    rstb = 0;
    #1;
    model_reset();
    check_all();
    cyc(2);
    rstb = 1; ev_ready = 1; comp_high = 4'h0;
    cyc(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
